key_setting_ctrl: RTL
=====================

Name: key_setting_ctrl

Overview:
- Consumes the single-cycle positive pulses produced by three debounced key stages (mode, up, down).
- Maintains a shadow copy of the test-pattern selection and brightness level. Repeated same-direction key presses accelerate the level step.
- Commits the shadow to the active outputs only on a frame boundary, so the HDMI pattern generator never changes settings mid-frame.
- Sits between the key input stages and the video pattern generator.

Parameters:
- NUM_PATTERNS, 8, number of selectable patterns; pattern index wraps modulo this value.
- LEVEL_W, 8, width of the brightness level.
- LEVEL_RESET, 128, level value after reset.
- STEP_FINE, 1, level step before acceleration.
- STEP_COARSE, 16, level step once accelerated.
- ACCEL_COUNT, 4, consecutive same-direction pulses needed to switch to coarse stepping.
- ACCEL_WINDOW, 25_000_000, max cycles allowed between pulses for the streak to continue.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- mode_pulse  input  1  one-cycle pulse: advance pattern
- up_pulse  input  1  one-cycle pulse: increase level
- down_pulse  input  1  one-cycle pulse: decrease level
- frame_start  input  1  one-cycle pulse at start of vertical blanking
- pattern  output  $clog2(NUM_PATTERNS)  active pattern index
- level  output  LEVEL_W  active brightness level
- update  output  1  one-cycle pulse when a commit occurs
- pending  output  1  high while shadow holds uncommitted changes

Behaviour:
- Reset (async, active-low):
  - shadow and active pattern = 0; shadow and active level = LEVEL_RESET.
  - update = 0, pending = 0, streak = 0, window timer = 0, FSM = IDLE.
- Pattern: each mode_pulse sets shadow_pattern = (shadow_pattern+1) mod NUM_PATTERNS; NUM_PATTERNS-1 wraps to 0.
- Level direction:
  - up_pulse alone = +step; down_pulse alone = -step.
  - up and down in the same cycle cancel: level unchanged, streak cleared to 0.
- Level arithmetic: computed at LEVEL_W+1 bits, saturated to 0..2^LEVEL_W-1. No wrap-around.
- Streak tracking:
  - A pulse in the same direction as the previous one, with the window timer not expired, increments the streak (saturating at ACCEL_COUNT).
  - Otherwise the streak is set to 1 and the direction is recorded.
  - The window timer restarts at 0 on every up/down pulse. When it reaches ACCEL_WINDOW-1 the streak clears to 0.
- Step selection: step = STEP_COARSE if the streak after the current pulse ≥ ACCEL_COUNT, else STEP_FINE.
- Change definition: a cycle is a "change" if the shadow pattern or shadow level differs from its previous shadow value. A saturated up at max or down at 0 is not a change.
- FSM:
  - IDLE: change → PENDING.
  - PENDING, frame_start: active ← shadow as registered at the start of that cycle; update = 1 next cycle.
    - If a change also occurs in that cycle, stay PENDING.
    - Otherwise go to IDLE.
  - PENDING, no frame_start: hold.
  - frame_start in IDLE: no effect; update stays 0.
- Output timing:
  - pending = (FSM == PENDING), registered.
  - update is high for exactly one cycle, in the cycle after the commit edge. pattern and level change on that same edge.
- Latency:
  - Key pulse → shadow: 1 cycle.
  - Shadow → outputs: the next frame_start plus 1 cycle.
- Reset mid-operation: uncommitted shadow changes are discarded; all state returns to reset values.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package setting_pkg:
  - state_t enum {IDLE, PENDING}
  - dir_t enum {DIR_NONE, DIR_UP, DIR_DOWN}
- One sub-module, step_accel:
  - Contains the streak counter, direction register and window timer.
  - Inputs: clk, reset_n, up, down. Output: step value.
- The top level keeps the shadow/active registers and the FSM.

Test Plan:
- Reset, then 3 mode_pulses → pattern stays 0 and pending=1. Then frame_start → next cycle pattern=3, level=128, update=1 for one cycle, pending=0.
- 9 mode_pulses from reset, then frame_start → pattern=1 (wrap at 8).
- 5 up_pulses 100 cycles apart, then frame_start → level = 128+1+1+1+16+16 = 163.
- up_pulse ×3, then a wait > ACCEL_WINDOW, then up_pulse, then frame_start → level = 128+4 = 132 (streak restarted, fine step).
- From level 255, up_pulse → pending stays 0 and frame_start gives update=0. up and down in the same cycle → no change, pending stays 0.
- Change pending, mode_pulse coincident with frame_start → previous shadow committed, update=1, pending stays 1. The next frame_start commits the new pattern.

Source files
------------

// File: rtl/setting_pkg.sv
// Shared types for the key setting controller: commit FSM states and key direction.
package setting_pkg;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

endpackage

// File: rtl/key_setting_ctrl_step_accel.sv
// Level step generator: tracks a same-direction press streak inside a time window
// and switches from fine to coarse stepping once the streak is long enough.
module step_accel
    import setting_pkg::*;
#(
    parameter int LEVEL_W      = 8,
    parameter int STEP_FINE    = 1,
    parameter int STEP_COARSE  = 16,
    parameter int ACCEL_COUNT  = 4,
    parameter int ACCEL_WINDOW = 25_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               up,
    input  logic               down,
    output logic [LEVEL_W-1:0] step
);

    localparam int CNT_W = $clog2(ACCEL_COUNT + 1);
    localparam int TMR_W = $clog2(ACCEL_WINDOW);

    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] streak_next;
    logic [TMR_W-1:0] timer;
    dir_t             dir;
    dir_t             pulse_dir;
    logic             expired;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pulse_dir   = up ? DIR_UP : DIR_DOWN;
        expired     = (timer == TMR_W'(ACCEL_WINDOW - 1));
        streak_next = CNT_W'(1);
        if (dir == pulse_dir && !expired) begin
            streak_next = (streak >= CNT_W'(ACCEL_COUNT)) ? CNT_W'(ACCEL_COUNT)
                                                           : streak + 1'b1;
        end
        step = (streak_next >= CNT_W'(ACCEL_COUNT)) ? LEVEL_W'(STEP_COARSE)
                                                     : LEVEL_W'(STEP_FINE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak <= '0;
            timer  <= '0;
            dir    <= DIR_NONE;
        end else if (up && down) begin
            streak <= '0;
            timer  <= '0;
            dir    <= DIR_NONE;
        end else if (up || down) begin
            streak <= streak_next;
            timer  <= '0;
            dir    <= pulse_dir;
        end else if (expired) begin
            // Timer parks at the window limit so the streak stays cleared.
            streak <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/key_setting_ctrl.sv
// Key-driven pattern/brightness settings: edits go to a shadow copy and are
// committed to the active outputs only on frame_start.
module key_setting_ctrl
    import setting_pkg::*;
#(
    parameter int NUM_PATTERNS = 8,
    parameter int LEVEL_W      = 8,
    parameter int LEVEL_RESET  = 128,
    parameter int STEP_FINE    = 1,
    parameter int STEP_COARSE  = 16,
    parameter int ACCEL_COUNT  = 4,
    parameter int ACCEL_WINDOW = 25_000_000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            mode_pulse,
    input  logic                            up_pulse,
    input  logic                            down_pulse,
    input  logic                            frame_start,
    output logic [$clog2(NUM_PATTERNS)-1:0] pattern,
    output logic [LEVEL_W-1:0]              level,
    output logic                            update,
    output logic                            pending
);

    localparam int PAT_W = $clog2(NUM_PATTERNS);

    logic [PAT_W-1:0]   shadow_pattern, next_pattern;
    logic [LEVEL_W-1:0] shadow_level, next_level;
    logic [LEVEL_W-1:0] step;
    logic [LEVEL_W:0]   level_wide;
    logic               change;
    state_t             state;

    step_accel #(
        .LEVEL_W     (LEVEL_W),
        .STEP_FINE   (STEP_FINE),
        .STEP_COARSE (STEP_COARSE),
        .ACCEL_COUNT (ACCEL_COUNT),
        .ACCEL_WINDOW(ACCEL_WINDOW)
    ) u_step_accel (
        .clk    (clk),
        .reset_n(reset_n),
        .up     (up_pulse),
        .down   (down_pulse),
        .step   (step)
    );

    always_comb begin
        next_pattern = shadow_pattern;
        next_level   = shadow_level;
        level_wide   = {1'b0, shadow_level};
        if (mode_pulse) begin
            next_pattern = (shadow_pattern == PAT_W'(NUM_PATTERNS - 1)) ? '0
                                                                        : shadow_pattern + 1'b1;
        end
        // Extra MSB is the carry (up) or borrow (down) used for saturation.
        if (up_pulse && !down_pulse) begin
            level_wide = {1'b0, shadow_level} + {1'b0, step};
            next_level = level_wide[LEVEL_W] ? '1 : level_wide[LEVEL_W-1:0];
        end else if (down_pulse && !up_pulse) begin
            level_wide = {1'b0, shadow_level} - {1'b0, step};
            next_level = level_wide[LEVEL_W] ? '0 : level_wide[LEVEL_W-1:0];
        end
        change = (next_pattern != shadow_pattern) || (next_level != shadow_level);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_pattern <= '0;
            shadow_level   <= LEVEL_W'(LEVEL_RESET);
            pattern        <= '0;
            level          <= LEVEL_W'(LEVEL_RESET);
            update         <= 1'b0;
            pending        <= 1'b0;
            state          <= IDLE;
        end else begin
            shadow_pattern <= next_pattern;
            shadow_level   <= next_level;
            update         <= 1'b0;
            case (state)
                IDLE: begin
                    if (change) begin
                        state   <= PENDING;
                        pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        // Commit the pre-edge shadow; a same-cycle edit waits for the next frame.
                        pattern <= shadow_pattern;
                        level   <= shadow_level;
                        update  <= 1'b1;
                        state   <= change ? PENDING : IDLE;
                        pending <= change;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
